// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART receiver: SOF, LEN, payload, XOR checksum.
// Verified payloads are buffered and drained over a valid/ready stream.
module uart_rx_pkt_ctrl #(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SOF          = 8'h7E,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       os_tick,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       parity_error,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic [2:0] err_code
);

   localparam int unsigned PW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TLIM   = TIMEOUT_BITS * 16;
   localparam int unsigned TW     = $clog2(TLIM + 1);
   localparam logic [7:0]  MaxLen = 8'(MAX_LEN);

   typedef enum logic [2:0] {StHunt, StLen, StPayload, StChk, StDrain} state_e;

   state_e          state_q;
   logic [7:0]      len_q;
   logic [7:0]      chk_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [TW-1:0]   tmo_q;
   logic [7:0]      buf_q [MAX_LEN];
   logic [7:0]      out_data_q;
   logic            out_valid_q;
   logic            out_last_q;
   logic            pkt_ok_q;
   logic            pkt_err_q;
   logic [2:0]      err_code_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StHunt;
         len_q       <= '0;
         chk_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tmo_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pkt_ok_q    <= 1'b0;
         pkt_err_q   <= 1'b0;
         err_code_q  <= '0;
         for (int i = 0; i < int'(MAX_LEN); i++) buf_q[i] <= '0;
      end else begin
         pkt_ok_q  <= 1'b0;
         pkt_err_q <= 1'b0;
         case (state_q)
            StHunt: begin
               tmo_q <= '0;
               if (rx_done && !parity_error && rx_data == SOF) state_q <= StLen;
            end
            StLen, StPayload, StChk: begin
               if (rx_done) begin
                  tmo_q <= '0;
                  // Parity abort wins over any content check on the same byte.
                  if (parity_error) begin
                     state_q    <= StHunt;
                     pkt_err_q  <= 1'b1;
                     err_code_q <= 3'd2;
                  end else if (state_q == StLen) begin
                     if (rx_data != 8'd0 && rx_data <= MaxLen) begin
                        len_q    <= rx_data;
                        chk_q    <= rx_data;
                        wr_ptr_q <= '0;
                        state_q  <= StPayload;
                     end else begin
                        state_q    <= StHunt;
                        pkt_err_q  <= 1'b1;
                        err_code_q <= 3'd1;
                     end
                  end else if (state_q == StPayload) begin
                     buf_q[wr_ptr_q] <= rx_data;
                     chk_q           <= chk_q ^ rx_data;
                     wr_ptr_q        <= wr_ptr_q + PW'(1);
                     if (8'(wr_ptr_q) == len_q - 8'd1) state_q <= StChk;
                  end else begin
                     if (rx_data == chk_q) begin
                        pkt_ok_q    <= 1'b1;
                        rd_ptr_q    <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= buf_q[0];
                        out_last_q  <= (len_q == 8'd1);
                        state_q     <= StDrain;
                     end else begin
                        state_q    <= StHunt;
                        pkt_err_q  <= 1'b1;
                        err_code_q <= 3'd4;
                     end
                  end
               end else if (os_tick) begin
                  if (tmo_q == TW'(TLIM - 1)) begin
                     tmo_q      <= '0;
                     state_q    <= StHunt;
                     pkt_err_q  <= 1'b1;
                     err_code_q <= 3'd3;
                  end else if (tmo_q != TW'(TLIM)) begin
                     tmo_q <= tmo_q + TW'(1);
                  end
               end
            end
            StDrain: begin
               // Overrun: the byte is lost but the buffered packet keeps draining.
               if (rx_done) begin
                  pkt_err_q  <= 1'b1;
                  err_code_q <= 3'd5;
               end
               if (out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     state_q     <= StHunt;
                  end else begin
                     rd_ptr_q   <= rd_ptr_q + PW'(1);
                     out_data_q <= buf_q[rd_ptr_q + PW'(1)];
                     out_last_q <= (8'(rd_ptr_q) + 8'd1 == len_q - 8'd1);
                  end
               end
            end
            default: state_q <= StHunt;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign pkt_ok    = pkt_ok_q;
   assign pkt_err   = pkt_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: directed frames, expected stream bytes
// and ok/error events are queued by the stimulus and popped by a monitor.
module tb_uart_rx_pkt_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       os_tick;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       parity_error;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       pkt_ok;
   logic       pkt_err;
   logic [2:0] err_code;

   uart_rx_pkt_ctrl #(
      .MAX_LEN      (16),
      .SOF          (8'h7E),
      .TIMEOUT_BITS (20)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .os_tick      (os_tick),
      .rx_data      (rx_data),
      .rx_done      (rx_done),
      .parity_error (parity_error),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .pkt_ok       (pkt_ok),
      .pkt_err      (pkt_err),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [8:0] exp_data_q [$];  // {last, data}
   int         exp_ev_q   [$];  // 0 = pkt_ok, else expected err_code
   logic [7:0] pl [16];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a handshake or event.
   always @(negedge clk) begin
      logic [8:0] e;
      int         ev;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_byte: got %0h, expected none", out_data);
            end else begin
               e = exp_data_q.pop_front();
               check("out_data", int'(out_data), int'(e[7:0]));
               check("out_last", int'(out_last), int'(e[8]));
            end
         end
         if (pkt_ok || pkt_err) begin
            if (exp_ev_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_event: got ok=%0b err=%0b code=%0d, expected none",
                        pkt_ok, pkt_err, err_code);
            end else begin
               ev = exp_ev_q.pop_front();
               check("event_code", pkt_ok ? 0 : int'(err_code), ev);
               check("event_exclusive", int'(pkt_ok && pkt_err), 0);
            end
         end
      end
   end

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic par);
      rx_data      = b;
      rx_done      = 1'b1;
      parity_error = par;
      cycle(1);
      rx_done      = 1'b0;
      parity_error = 1'b0;
      rx_data      = 8'h00;
      cycle(1);
   endtask

   // Sends SOF, LEN=n, pl[0..n-1] and the checksum XORed with adj.
   task automatic send_frame(input int n, input logic [7:0] adj);
      logic [7:0] c;
      c = 8'(n);
      for (int i = 0; i < n; i++) c = c ^ pl[i];
      send_byte(8'h7E, 1'b0);
      send_byte(8'(n), 1'b0);
      for (int i = 0; i < n; i++) send_byte(pl[i], 1'b0);
      send_byte(c ^ adj, 1'b0);
   endtask

   task automatic expect_pkt(input int n);
      for (int i = 0; i < n; i++) exp_data_q.push_back({(i == n - 1), pl[i]});
      exp_ev_q.push_back(0);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (out_valid && k < 200) begin
         cycle(1);
         k++;
      end
      check("drain_completes", int'(out_valid), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_data"},  int'(out_data),  0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_last"},  int'(out_last),  0);
      check({tag, "_pkt_ok"},    int'(pkt_ok),    0);
      check({tag, "_pkt_err"},   int'(pkt_err),   0);
      check({tag, "_err_code"},  int'(err_code),  0);
   endtask

   task automatic load3();
      pl[0] = 8'h11;
      pl[1] = 8'h22;
      pl[2] = 8'h33;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; os_tick = 1'b0; rx_data = 8'h00; rx_done = 1'b0;
      parity_error = 1'b0; out_ready = 1'b1;
      cycle(3);
      check_all_zero("reset");
      rst = 1'b0;
      cycle(2);

      // Good packet, full-rate drain.
      load3();
      expect_pkt(3);
      send_frame(3, 8'h00);
      wait_idle();
      check("err_code_after_good", int'(err_code), 0);

      // Backpressure: ready pattern 1,0,0,1 starting with pkt_ok.
      out_ready = 1'b0;
      expect_pkt(3);
      rx_data = 8'h7E; rx_done = 1'b1; cycle(1); rx_done = 1'b0; cycle(1);
      rx_data = 8'h03; rx_done = 1'b1; cycle(1); rx_done = 1'b0; cycle(1);
      for (int i = 0; i < 3; i++) send_byte(pl[i], 1'b0);
      rx_data = 8'h03; rx_done = 1'b1; cycle(1); rx_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         out_ready = (i % 4 == 0) || (i % 4 == 3);
         cycle(1);
      end
      out_ready = 1'b1;
      wait_idle();

      // Bad checksum: 04 instead of 03.
      exp_ev_q.push_back(4);
      send_frame(3, 8'h07);
      cycle(2);
      check("bad_chk_no_valid", int'(out_valid), 0);
      check("bad_chk_code", int'(err_code), 4);

      // Length boundaries and parity.
      exp_ev_q.push_back(1);
      send_byte(8'h7E, 1'b0); send_byte(8'h00, 1'b0);
      exp_ev_q.push_back(1);
      send_byte(8'h7E, 1'b0); send_byte(8'h11, 1'b0);
      check("len17_code", int'(err_code), 1);
      exp_ev_q.push_back(2);
      send_byte(8'h7E, 1'b0); send_byte(8'h03, 1'b1);
      check("parity_code", int'(err_code), 2);

      // Maximum length packet.
      for (int i = 0; i < 16; i++) pl[i] = 8'(i * 17 + 3);
      expect_pkt(16);
      send_frame(16, 8'h00);
      wait_idle();

      // Timeout after 7E 02 AA: error exactly after the 320th tick.
      send_byte(8'h7E, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'hAA, 1'b0);
      for (int i = 0; i < 319; i++) begin
         os_tick = 1'b1;
         cycle(1);
      end
      os_tick = 1'b0;
      check("no_early_timeout", int'(pkt_err), 0);
      exp_ev_q.push_back(3);
      os_tick = 1'b1;
      cycle(1);
      os_tick = 1'b0;
      check("timeout_pulse", int'(pkt_err), 1);
      check("timeout_code", int'(err_code), 3);
      cycle(1);
      pl[0] = 8'h5A; pl[1] = 8'hC3;
      expect_pkt(2);
      send_frame(2, 8'h00);
      wait_idle();

      // Overrun while stalled; payload must still arrive intact.
      load3();
      out_ready = 1'b0;
      expect_pkt(3);
      send_frame(3, 8'h00);
      exp_ev_q.push_back(5);
      send_byte(8'h55, 1'b0);
      check("overrun_code", int'(err_code), 5);
      check("overrun_valid_held", int'(out_valid), 1);
      out_ready = 1'b1;
      wait_idle();

      // Garbage in HUNT, then single-byte packet.
      send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h7D, 1'b0);
      pl[0] = 8'hA5;
      expect_pkt(1);
      send_frame(1, 8'h00);
      wait_idle();

      // Reset mid-PAYLOAD.
      send_byte(8'h7E, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h11, 1'b0);
      rst = 1'b1;
      cycle(1);
      check_all_zero("rst_payload");
      rst = 1'b0;
      cycle(1);

      // Reset mid-DRAIN; buffered bytes are abandoned.
      load3();
      out_ready = 1'b0;
      exp_ev_q.push_back(0);
      send_frame(3, 8'h00);
      rst = 1'b1;
      cycle(1);
      check_all_zero("rst_drain");
      rst = 1'b0;
      out_ready = 1'b1;
      cycle(1);
      expect_pkt(3);
      send_frame(3, 8'h00);
      wait_idle();

      cycle(5);
      check("data_queue_empty", exp_data_q.size(), 0);
      check("event_queue_empty", exp_ev_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
# uart_rx_pkt_ctrl

Packet-level controller sitting directly behind the oversampled UART receiver. It consumes the receiver's byte stream (`rx_data`/`rx_done`/`parity_error`) and sequences it through a framing state machine: start-of-frame, length, payload, checksum. The payload is buffered and released downstream over a valid/ready stream only if the checksum matches. Malformed, parity-corrupted, truncated or overrunning packets are dropped and reported with an error code.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes (1..255); buffer depth.
- `SOF`, 8'h7E: start-of-frame byte value.
- `TIMEOUT_BITS`, 20: inter-byte timeout in bit periods (16 `os_tick` each).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `os_tick`  in  1  16x-baud oversample strobe, same one feeding the receiver.
- `rx_data`  in  8  received byte, valid when `rx_done`=1.
- `rx_done`  in  1  one-cycle byte strobe from receiver.
- `parity_error`  in  1  receiver parity flag, sampled only when `rx_done`=1.
- `out_data`  out  8  payload byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts when `out_valid`&&`out_ready`.
- `out_last`  out  1  marks final payload byte; qualified by `out_valid`.
- `pkt_ok`  out  1  one-cycle pulse: checksum matched, drain starting.
- `pkt_err`  out  1  one-cycle pulse: packet dropped.
- `err_code`  out  3  cause, held from `pkt_err` until next `pkt_err` or reset: 1 bad length, 2 parity, 3 timeout, 4 checksum, 5 overrun.

## Operation
- States: HUNT, LEN, PAYLOAD, CHK, DRAIN.
- HUNT:
  - `rx_done` with `rx_data`==`SOF` and no parity error -> LEN.
  - Any other byte is discarded silently.
- LEN:
  - Byte must be 1..`MAX_LEN`. Store it as `len`, set `chk_acc`=byte, set `wr_ptr`=0, -> PAYLOAD.
  - 0 or >`MAX_LEN` -> error 1, -> HUNT.
- PAYLOAD:
  - Each byte: `buf[wr_ptr]`<=byte, `chk_acc`^=byte, `wr_ptr`++.
  - On the `len`-th byte -> CHK.
- CHK:
  - Byte == `chk_acc` -> `pkt_ok`, `rd_ptr`=0, -> DRAIN.
  - Otherwise error 4, -> HUNT.
- Checksum definition: XOR of LEN byte and all payload bytes. The SOF byte is excluded.
- Parity: any `rx_done` with `parity_error`=1 in LEN/PAYLOAD/CHK -> error 2, -> HUNT. Parity abort takes priority over length/checksum checks on that byte.
- Timeout:
  - Counter increments on `os_tick` in LEN/PAYLOAD/CHK only.
  - Cleared on every `rx_done` and on each state entry.
  - Reaching `TIMEOUT_BITS`*16 -> error 3, -> HUNT.
  - This also catches frames the receiver drops for a bad stop bit, since those produce no `rx_done`.
- DRAIN:
  - `out_data`=`buf[rd_ptr]`, `out_valid`=1, `out_last`=(`rd_ptr`==`len`-1).
  - Each handshake increments `rd_ptr`. The handshake on the last byte -> HUNT.
  - No timeout in DRAIN.
- Overrun:
  - An `rx_done` during DRAIN is discarded, asserts `pkt_err` with code 5, and increments nothing else.
  - Drain continues, so the buffered packet is still delivered intact.
- Arithmetic:
  - `wr_ptr`/`rd_ptr` are $clog2(`MAX_LEN`) bits (minimum 1) and are never compared beyond `len`-1.
  - Timeout counter is wide enough for `TIMEOUT_BITS`*16, saturating.

## Timing
- Reset values:
  - `out_data` 0, `out_valid` 0, `out_last` 0, `pkt_ok` 0, `pkt_err` 0, `err_code` 0.
  - State HUNT; all pointers and counters 0.
- Reset mid-packet or mid-drain: the next cycle has `out_valid`=0 and state HUNT. Buffered data is abandoned with no error pulse.
- All `rx_done` processing is registered: state/buffer update the cycle after the strobe. `pkt_ok`/`pkt_err` are asserted in that same update cycle.
- DRAIN latency:
  - `out_valid` first asserts the cycle after the CHK byte's `rx_done`, coincident with `pkt_ok`.
  - Zero-bubble: one byte per cycle while `out_ready`=1.
- `out_data`/`out_last` are stable while `out_valid`&&!`out_ready`. `out_valid` never drops without a handshake, except on reset.
- The cycle after the final handshake, `out_valid`=0 and state is HUNT. An SOF arriving that same cycle is accepted.
- `rx_done` and timeout expiry in the same cycle: `rx_done` wins; the byte is processed and the counter cleared.
- `pkt_err` is a single cycle per event. A new error overwrites `err_code`.

## Test plan
- Good packet with `out_ready`=1:
  - Bytes 7E 03 11 22 33 03 -> `pkt_ok` pulse.
  - `out_data` 11, 22, 33 on 3 consecutive cycles, `out_last` on 33.
  - Then HUNT, `err_code` stays 0.
- Backpressure: same packet, `out_ready` toggled 1,0,0,1,… -> bytes 11/22/33 held stable across stalls, no loss or duplication, `out_last` only with 33.
- Errors:
  - 7E 03 11 22 33 04 -> `pkt_err`, `err_code`=4, `out_valid` never set.
  - 7E 00 -> code 1.
  - 7E 11 (MAX_LEN=16) -> code 1.
  - Byte with `parity_error`=1 after 7E -> code 2.
- Timeout: 7E 02 AA, then silence for 320 `os_tick` -> `pkt_err` code 3 exactly at the 320th tick. A subsequent good packet is received correctly.
- Overrun and garbage in HUNT:
  - Stall `out_ready`=0 after `pkt_ok`, inject byte 55 -> `pkt_err` code 5. Original payload is still delivered intact once `out_ready`=1.
  - Garbage 00 FF 7D before 7E is ignored without error.
- Reset mid-PAYLOAD and mid-DRAIN -> next cycle `out_valid`=0, all outputs 0. A following good packet is processed normally.
